// File: rtl/centronics_sink.sv
// centronics_sink: parallel-port strobe receiver with nACK handshake and a FWFT byte FIFO
// drained by a valid/ready consumer.
module centronics_sink #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ACK_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  CLK_en,
  input  logic [7:0]            PDATA,
  input  logic                  nSTROBE,
  output logic                  nACK,
  output logic                  BUSY,
  output logic [7:0]            OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERRUN,
  input  logic                  OVERRUN_CLR
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  state_t                r_state, w_next;
  logic                  r_sync1, r_sync2, r_prev;
  logic [1:0]            r_warm;
  logic [7:0]            r_pdata, r_cnt;
  logic [DEPTH_LOG2-1:0] r_wr, r_rd;
  logic [DEPTH_LOG2:0]   r_level;
  logic [7:0]            r_mem [DEPTH];
  logic                  r_ovr;
  logic                  w_stb_fall, w_full, w_push, w_pop;
  // r_warm keeps r_prev low until the synchroniser holds real samples, so a strobe
  // already low at reset release cannot look like a falling edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_warm  <= 2'b00;
      r_prev  <= 1'b0;
      r_pdata <= 8'h00;
    end else begin
      r_sync1 <= nSTROBE;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      r_prev  <= r_sync2 & r_warm[1];
      r_pdata <= PDATA;
    end
  end
  assign w_stb_fall = r_prev & ~r_sync2;
  assign w_full     = r_level == (DEPTH_LOG2+1)'(DEPTH);
  assign w_push     = (r_state == IDLE) & w_stb_fall & ~w_full;
  assign w_pop      = OUT_VALID & OUT_READY;
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_push ? ACK : IDLE;
      ACK:     w_next = (CLK_en && r_cnt == 8'd1) ? (w_full ? HOLD : IDLE) : ACK;
      HOLD:    w_next = w_full ? HOLD : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    nACK = r_state != ACK;
    BUSY = (r_state != IDLE) || w_full;
  end
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_cnt   <= 8'd0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_cnt   <= w_push ? 8'(ACK_CYCLES) : (r_state == ACK && CLK_en) ? r_cnt - 8'd1 : r_cnt;
      r_wr    <= r_wr + DEPTH_LOG2'(w_push);
      r_rd    <= r_rd + DEPTH_LOG2'(w_pop);
      r_level <= r_level + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      r_ovr   <= (w_stb_fall & ~w_push) ? 1'b1 : OVERRUN_CLR ? 1'b0 : r_ovr;
    end
  end
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= r_pdata;
  end
  assign OUT_DATA  = r_mem[r_rd];
  assign OUT_VALID = r_level != '0;
  assign LEVEL     = r_level;
  assign OVERRUN   = r_ovr;
endmodule

// File: tb/tb_centronics_sink.sv
// tb_centronics_sink: directed bench for centronics_sink; a second instance with a
// 3-cycle ACK checks pulse width under a sparse CLK_en.
module tb_centronics_sink;
  logic       CLK = 1'b0;
  logic       nRESET, CLK_en, nSTROBE, OUT_READY, OVERRUN_CLR;
  logic [7:0] PDATA;
  logic       nACK, BUSY, OUT_VALID, OVERRUN;
  logic [7:0] OUT_DATA;
  logic [3:0] LEVEL;
  logic       sp_nack, sp_busy, sp_valid, sp_ovr;
  logic [7:0] sp_data;
  logic [3:0] sp_level;
  logic       sparse = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 CLK = ~CLK;

  centronics_sink #(.DEPTH_LOG2(3), .ACK_CYCLES(4)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_en(CLK_en), .PDATA(PDATA), .nSTROBE(nSTROBE),
    .nACK(nACK), .BUSY(BUSY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .LEVEL(LEVEL), .OVERRUN(OVERRUN), .OVERRUN_CLR(OVERRUN_CLR)
  );

  centronics_sink #(.DEPTH_LOG2(3), .ACK_CYCLES(3)) u_sp (
    .CLK(CLK), .nRESET(nRESET), .CLK_en(CLK_en), .PDATA(PDATA), .nSTROBE(nSTROBE),
    .nACK(sp_nack), .BUSY(sp_busy), .OUT_DATA(sp_data), .OUT_VALID(sp_valid),
    .OUT_READY(OUT_READY), .LEVEL(sp_level), .OVERRUN(sp_ovr), .OVERRUN_CLR(OVERRUN_CLR)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    if (sparse) CLK_en = ~CLK_en;
  endtask

  // Strobe low for one cycle; returns just after edge 2 (push edge). pop drives
  // OUT_READY during the push cycle.
  task automatic send(input logic [7:0] d, input logic pop);
    PDATA = d;
    nSTROBE = 1'b0;
    tick;
    nSTROBE = 1'b1;
    tick;
    OUT_READY = pop;
    tick;
    OUT_READY = 1'b0;
  endtask

  task automatic wait_ack;
    int n = 0;
    while (nACK !== 1'b1 && n < 30) begin
      tick;
      n++;
    end
    chk("ack_end", 8'(nACK), 8'd1);
  endtask

  task automatic do_reset;
    nRESET = 1'b0;
    tick;
    nRESET = 1'b1;
    repeat (3) tick;
  endtask

  initial begin
    nRESET = 1'b0; CLK_en = 1'b1; PDATA = 8'h00; nSTROBE = 1'b1;
    OUT_READY = 1'b0; OVERRUN_CLR = 1'b0;
    tick; tick;
    chk("rst_nack", 8'(nACK), 8'd1);
    chk("rst_busy", 8'(BUSY), 8'd0);
    chk("rst_valid", 8'(OUT_VALID), 8'd0);
    chk("rst_level", 8'(LEVEL), 8'd0);
    chk("rst_ovr", 8'(OVERRUN), 8'd0);
    nRESET = 1'b1;
    repeat (3) tick;

    // single byte, latency and ACK width
    PDATA = 8'hA5; nSTROBE = 1'b0;
    tick;
    chk("e0_level", 8'(LEVEL), 8'd0);
    nSTROBE = 1'b1;
    tick;
    chk("e1_level", 8'(LEVEL), 8'd0);
    chk("e1_nack", 8'(nACK), 8'd1);
    tick;
    chk("e2_level", 8'(LEVEL), 8'd1);
    chk("e2_valid", 8'(OUT_VALID), 8'd1);
    chk("e2_data", OUT_DATA, 8'hA5);
    chk("e2_nack", 8'(nACK), 8'd0);
    chk("e2_busy", 8'(BUSY), 8'd1);
    repeat (3) tick;
    chk("ack_low_4th", 8'(nACK), 8'd0);
    tick;
    chk("ack_rise", 8'(nACK), 8'd1);
    chk("busy_fall", 8'(BUSY), 8'd0);
    OUT_READY = 1'b1;
    tick;
    OUT_READY = 1'b0;
    chk("pop_level", 8'(LEVEL), 8'd0);
    chk("pop_valid", 8'(OUT_VALID), 8'd0);

    // fill to full honouring BUSY
    for (int i = 1; i <= 8; i++) begin
      chk("fill_busy", 8'(BUSY), 8'd0);
      send(8'(i), 1'b0);
      wait_ack;
    end
    chk("full_busy", 8'(BUSY), 8'd1);
    chk("full_level", 8'(LEVEL), 8'd8);
    tick;
    chk("hold_busy", 8'(BUSY), 8'd1);
    chk("hold_nack", 8'(nACK), 8'd1);
    chk("head_01", OUT_DATA, 8'h01);
    OUT_READY = 1'b1;
    tick;
    OUT_READY = 1'b0;
    chk("hold_pop_level", 8'(LEVEL), 8'd7);
    chk("hold_pop_busy", 8'(BUSY), 8'd1);
    tick;
    chk("hold_exit_busy", 8'(BUSY), 8'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("drain_data", OUT_DATA, 8'(i));
      OUT_READY = 1'b1;
      tick;
      OUT_READY = 1'b0;
    end
    chk("drain_level", 8'(LEVEL), 8'd0);

    // overrun during ACK, then clear
    send(8'h11, 1'b0);
    send(8'hEE, 1'b0);
    chk("ovr_set", 8'(OVERRUN), 8'd1);
    chk("ovr_level", 8'(LEVEL), 8'd1);
    wait_ack;
    OVERRUN_CLR = 1'b1;
    tick;
    OVERRUN_CLR = 1'b0;
    chk("ovr_clr", 8'(OVERRUN), 8'd0);
    // set and clear in the same cycle: set wins
    send(8'h22, 1'b0);
    PDATA = 8'hDD; nSTROBE = 1'b0;
    tick;
    nSTROBE = 1'b1;
    tick;
    OVERRUN_CLR = 1'b1;
    tick;
    OVERRUN_CLR = 1'b0;
    chk("ovr_set_wins", 8'(OVERRUN), 8'd1);
    chk("ovr2_level", 8'(LEVEL), 8'd2);
    wait_ack;
    OVERRUN_CLR = 1'b1;
    tick;
    OVERRUN_CLR = 1'b0;
    chk("ovr_clr2", 8'(OVERRUN), 8'd0);
    chk("ovr_head", OUT_DATA, 8'h11);
    OUT_READY = 1'b1;
    tick;
    chk("ovr_head2", OUT_DATA, 8'h22);
    tick;
    OUT_READY = 1'b0;
    chk("ovr_drain", 8'(LEVEL), 8'd0);

    // concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      send(8'h31 + 8'(i), 1'b0);
      wait_ack;
    end
    chk("cc_level3", 8'(LEVEL), 8'd3);
    send(8'h34, 1'b1);
    chk("cc_level_same", 8'(LEVEL), 8'd3);
    chk("cc_head_adv", OUT_DATA, 8'h32);
    wait_ack;
    for (int i = 0; i < 5; i++) begin
      send(8'h35 + 8'(i), 1'b0);
      wait_ack;
    end
    chk("cc_full", 8'(LEVEL), 8'd8);
    chk("cc_full_busy", 8'(BUSY), 8'd1);
    send(8'h40, 1'b0);
    chk("cc_drop_ovr", 8'(OVERRUN), 8'd1);
    chk("cc_drop_level", 8'(LEVEL), 8'd8);
    chk("cc_drop_head", OUT_DATA, 8'h32);
    chk("cc_drop_nack", 8'(nACK), 8'd1);

    // reset mid-ACK, release with strobe held low
    do_reset;
    chk("rr_ovr", 8'(OVERRUN), 8'd0);
    send(8'h51, 1'b0);
    wait_ack;
    send(8'h52, 1'b0);
    chk("rr_level2", 8'(LEVEL), 8'd2);
    tick; tick;
    chk("rr_in_ack", 8'(nACK), 8'd0);
    nRESET = 1'b0; nSTROBE = 1'b0;
    #1;
    chk("rr_nack", 8'(nACK), 8'd1);
    chk("rr_level", 8'(LEVEL), 8'd0);
    chk("rr_valid", 8'(OUT_VALID), 8'd0);
    tick; tick;
    nRESET = 1'b1;
    repeat (5) tick;
    chk("rr_nopush", 8'(LEVEL), 8'd0);
    chk("rr_noack", 8'(nACK), 8'd1);
    nSTROBE = 1'b1;
    repeat (3) tick;
    chk("rr_still0", 8'(LEVEL), 8'd0);
    send(8'h53, 1'b0);
    chk("rr_fresh_level", 8'(LEVEL), 8'd1);
    chk("rr_fresh_data", OUT_DATA, 8'h53);
    wait_ack;

    // sparse CLK_en on the ACK_CYCLES=3 instance
    do_reset;
    sparse = 1'b1;
    tick; tick;
    PDATA = 8'h77; nSTROBE = 1'b0;
    tick;
    nSTROBE = 1'b1;
    tick;
    chk("sp_e1_level", 8'(sp_level), 8'd0);
    tick;
    chk("sp_e2_level", 8'(sp_level), 8'd1);
    chk("sp_e2_data", sp_data, 8'h77);
    chk("sp_e2_nack", 8'(sp_nack), 8'd0);
    begin
      int n = 0;
      while (sp_nack !== 1'b1 && n < 20) begin
        tick;
        n++;
      end
      chk("sp_ack_width", 8'(n >= 5 && n <= 6), 8'd1);
    end
    chk("sp_busy_end", 8'(sp_busy), 8'd0);
    sparse = 1'b0;
    CLK_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
